// File: rtl/btn_pkg.sv
// Shared types and helpers for the button conditioner.
package btn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_HELD         = 3'd2,
    ST_REPEAT       = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } btn_state_e;

  // One spare bit above the largest terminal count so the counter can never wrap.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $unsigned($clog2(m)) + 32'd1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce/auto-repeat FSM and counter.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned CLKS_TO_WAIT  = 2500000,
  parameter int unsigned REPEAT_DELAY  = 12500000,
  parameter int unsigned REPEAT_PERIOD = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_e_debug,
  input  logic i_repeat_en,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse,
  output logic o_release
);

  localparam int unsigned CW = cnt_width(CLKS_TO_WAIT, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] STABLE_LAST = CW'(CLKS_TO_WAIT - 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  logic          r_sync1;
  logic          r_sync2;
  btn_state_e    r_state;
  btn_state_e    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_level;
  logic          r_pulse;
  logic          r_release;
  logic          w_level_nxt;
  logic          w_pulse_nxt;
  logic          w_release_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_pulse   <= w_pulse_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Bypass outputs are computed from the first flop so the registered result equals "synced".
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_pulse_nxt   = 1'b0;
    w_release_nxt = 1'b0;

    if (i_e_debug) begin
      w_state_nxt   = ST_IDLE;
      w_cnt_nxt     = '0;
      w_level_nxt   = r_sync1;
      w_pulse_nxt   = r_sync1 & ~r_sync2;
      w_release_nxt = ~r_sync1 & r_sync2;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (r_sync2) begin
            w_state_nxt = ST_PRESS_WAIT;
            w_cnt_nxt   = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!r_sync2) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_nxt = ST_HELD;
            w_pulse_nxt = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        ST_HELD: begin
          if (!r_sync2) begin
            w_state_nxt = ST_RELEASE_WAIT;
            w_cnt_nxt   = '0;
          end else if (!i_repeat_en) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == DELAY_LAST) begin
            w_state_nxt = ST_REPEAT;
            w_pulse_nxt = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        ST_REPEAT: begin
          if (!r_sync2) begin
            w_state_nxt = ST_RELEASE_WAIT;
            w_cnt_nxt   = '0;
          end else if (!i_repeat_en) begin
            w_state_nxt = ST_HELD;
            w_cnt_nxt   = '0;
          end else if (r_cnt == PERIOD_LAST) begin
            w_pulse_nxt = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        ST_RELEASE_WAIT: begin
          if (r_sync2) begin
            w_state_nxt = ST_HELD;
            w_cnt_nxt   = '0;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_nxt   = ST_IDLE;
            w_release_nxt = 1'b1;
            w_cnt_nxt     = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
      // Level tracks whether the channel is in an accepted-press state after this edge.
      w_level_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_REPEAT) ||
                    (w_state_nxt == ST_RELEASE_WAIT);
    end
  end

  assign o_level   = r_level;
  assign o_pulse   = r_pulse;
  assign o_release = r_release;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: one independent btn_channel per button.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BUTTONS     = 3,
  parameter int unsigned CLKS_TO_WAIT  = 2500000,
  parameter int unsigned REPEAT_DELAY  = 12500000,
  parameter int unsigned REPEAT_PERIOD = 2500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 e_debug,
  input  logic [N_BUTTONS-1:0] repeat_en,
  input  logic [N_BUTTONS-1:0] btns_in,
  output logic [N_BUTTONS-1:0] btns_level,
  output logic [N_BUTTONS-1:0] btns_pulse,
  output logic [N_BUTTONS-1:0] btns_release
);

  for (genvar g = 0; g < int'(N_BUTTONS); g++) begin : g_ch
    btn_channel #(
      .CLKS_TO_WAIT (CLKS_TO_WAIT),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_e_debug  (e_debug),
      .i_repeat_en(repeat_en[g]),
      .i_btn      (btns_in[g]),
      .o_level    (btns_level[g]),
      .o_pulse    (btns_pulse[g]),
      .o_release  (btns_release[g])
    );
  end

endmodule
